// File: rtl/riscv_pkg.sv
// Shared types for the multi-cycle RISC-V control unit: ALU op codes,
// the opcodes the unit decodes, and the control FSM state encoding.
package riscv_pkg;

  localparam int DATA   = 32;
  localparam int OPCODE = 4;

  typedef enum logic [OPCODE-1:0] {
    AND = 4'b0000,
    OR  = 4'b0001,
    ADD = 4'b0010,
    XOR = 4'b0011
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  typedef enum logic [3:0] {
    RESET,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    MEM_ADDR,
    MEM_RD,
    MEM_WR,
    WB_ALU,
    WB_MEM,
    BRANCH,
    TRAP
  } ctrl_state_t;

endpackage

// File: rtl/riscv_mc_ctrl_alu_op_decode.sv
// Maps funct3/funct7 of an ALU instruction to the ALU operation code and
// flags encodings the datapath does not implement.
module alu_op_decode
  import riscv_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic       i_is_rtype,
  output alu_op_t    o_alu_op,
  output logic       o_legal
);

  always_comb begin
    o_alu_op = ADD;
    o_legal  = 1'b1;
    case (i_funct3)
      3'b000:  o_alu_op = ADD;
      3'b100:  o_alu_op = XOR;
      3'b110:  o_alu_op = OR;
      3'b111:  o_alu_op = AND;
      default: o_legal  = 1'b0;
    endcase
    // Only the base R-type encodings are supported; sub/sra variants trap.
    if (i_is_rtype && (i_funct7 != 7'b0000000)) o_legal = 1'b0;
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle control FSM: steps each instruction through fetch, decode,
// execute, memory and write-back, driving ALU op and datapath strobes.
module riscv_mc_ctrl
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA-1:0]   instr,
  input  logic              zero,
  input  logic              mem_ready,
  output logic [OPCODE-1:0] alu_op,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic              i_or_d,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pc_src,
  output logic              reg_write,
  output logic              mem_to_reg,
  output logic              illegal,
  output ctrl_state_t       dbg_state
);

  ctrl_state_t r_state;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  alu_op_t     w_dec_op;
  logic        w_dec_legal;
  alu_op_t     w_alu_op;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];

  alu_op_decode u_alu_op_decode (
    .i_funct3  (w_funct3),
    .i_funct7  (w_funct7),
    .i_is_rtype(w_opcode == OP_R),
    .o_alu_op  (w_dec_op),
    .o_legal   (w_dec_legal)
  );

  // Memory states hold until mem_ready; mem_ready elsewhere has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET;
    end else begin
      case (r_state)
        RESET:  r_state <= FETCH;
        FETCH:  if (mem_ready) r_state <= DECODE;
        DECODE: begin
          case (w_opcode)
            OP_R:      r_state <= w_dec_legal ? EXEC_R : TRAP;
            OP_I:      r_state <= w_dec_legal ? EXEC_I : TRAP;
            OP_LOAD,
            OP_STORE:  r_state <= (w_funct3 == F3_WORD) ? MEM_ADDR : TRAP;
            OP_BRANCH: r_state <= (w_funct3 == F3_BEQ) ? BRANCH : TRAP;
            default:   r_state <= TRAP;
          endcase
        end
        EXEC_R,
        EXEC_I:   r_state <= WB_ALU;
        MEM_ADDR: r_state <= (w_opcode == OP_LOAD) ? MEM_RD : MEM_WR;
        MEM_RD:   if (mem_ready) r_state <= WB_MEM;
        MEM_WR:   if (mem_ready) r_state <= FETCH;
        WB_ALU,
        WB_MEM,
        BRANCH:   r_state <= FETCH;
        TRAP:     r_state <= TRAP;
        default:  r_state <= TRAP;
      endcase
    end
  end

  always_comb begin
    w_alu_op   = AND;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (r_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        w_alu_op  = ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b10;
        w_alu_op  = ADD;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        w_alu_op  = w_dec_op;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_alu_op  = w_dec_op;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_alu_op  = ADD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      WB_ALU: reg_write = 1'b1;
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      // beq compares via XOR; zero means rs1 == rs2, so the branch is taken.
      BRANCH: begin
        alu_src_a = 1'b1;
        w_alu_op  = XOR;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      default: ;
    endcase
  end

  assign alu_op    = w_alu_op;
  assign illegal   = (r_state == TRAP);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl: the driver pushes the expected per-cycle
// outputs into a queue and a negedge monitor pops and compares them.
module tb_riscv_mc_ctrl;
  import riscv_pkg::*;

  localparam int W = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA-1:0]   instr = '0;
  logic              zero = 1'b0;
  logic              mem_ready = 1'b0;
  logic [OPCODE-1:0] alu_op;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic              i_or_d, mem_read, mem_write, ir_write, pc_write;
  logic              pc_src, reg_write, mem_to_reg, illegal;
  ctrl_state_t       dbg_state;

  riscv_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_fail = 0;

  // Word layout: state, alu_op, src_a, src_b, i_or_d, mem_read, mem_write,
  // ir_write, pc_write, pc_src, reg_write, mem_to_reg, illegal.
  function automatic logic [W-1:0] pk(ctrl_state_t st, alu_op_t op, logic sa,
      logic [1:0] sb, logic iod, logic mr, logic mw, logic irw, logic pcw,
      logic pcs, logic rw, logic m2r, logic ill);
    return {st, op, sa, sb, iod, mr, mw, irw, pcw, pcs, rw, m2r, ill};
  endfunction

  function automatic logic [W-1:0] e_reset();
    return pk(RESET, AND, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_fetch(logic r);
    return pk(FETCH, ADD, 0, 2'b01, 0, 1, 0, r, r, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_decode();
    return pk(DECODE, ADD, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_exec_r(alu_op_t op);
    return pk(EXEC_R, op, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_exec_i(alu_op_t op);
    return pk(EXEC_I, op, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_mem_addr();
    return pk(MEM_ADDR, ADD, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_mem_rd();
    return pk(MEM_RD, AND, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_mem_wr();
    return pk(MEM_WR, AND, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_wb_alu();
    return pk(WB_ALU, AND, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_wb_mem();
    return pk(WB_MEM, AND, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0);
  endfunction
  function automatic logic [W-1:0] e_branch(logic z);
    return pk(BRANCH, XOR, 1, 2'b00, 0, 0, 0, 0, z, 1, 0, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_trap();
    return pk(TRAP, AND, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  // Called at posedge+1: drives this cycle's inputs and queues its outputs.
  task automatic step(input logic rdy, input logic z, input logic [W-1:0] e,
                      input string t);
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Drops rst_n mid-cycle; outputs must fall back to RESET before the negedge.
  task automatic async_reset(input string t);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(e_reset());
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    step(0, 0, e_reset(), "rst_hold");
    rst_n = 1'b1;
    step(0, 0, e_reset(), "rst_one_cycle");
  endtask

  always @(negedge clk) begin : monitor
    logic [W-1:0] e, a;
    string        t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {dbg_state, alu_op, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
           ir_write, pc_write, pc_src, reg_write, mem_to_reg, illegal};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", t, a, e);
      end
    end
  end

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_SUB = 32'h402081B3;
  localparam logic [31:0] I_LW  = {12'd8, 5'd2, 3'b010, 5'd3, 7'b0000011};
  localparam logic [31:0] I_SW  = {7'd0, 5'd3, 5'd2, 3'b010, 5'd4, 7'b0100011};
  localparam logic [31:0] I_BEQ = {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011};
  localparam logic [31:0] I_JAL = {25'd0, 7'b1101111};

  logic [2:0] imm_f3[3]  = '{3'b100, 3'b110, 3'b111};
  alu_op_t    imm_op[3]  = '{XOR, OR, AND};

  initial begin
    @(posedge clk);
    #1;
    step(0, 0, e_reset(), "reset_state");
    step(1, 0, e_reset(), "reset_state_ready_hi");
    rst_n = 1'b1;
    step(1, 0, e_reset(), "reset_release_cycle");

    instr = I_ADD;
    step(1, 0, e_fetch(1), "add_fetch");
    step(1, 0, e_decode(), "add_decode");
    step(1, 0, e_exec_r(ADD), "add_exec");
    step(1, 0, e_wb_alu(), "add_wb");

    for (int i = 0; i < 3; i++) begin
      instr = {12'd5, 5'd1, imm_f3[i], 5'd2, 7'b0010011};
      step(1, 0, e_fetch(1), "imm_fetch");
      step(1, 0, e_decode(), "imm_decode");
      step(1, 0, e_exec_i(imm_op[i]), "imm_exec");
      step(1, 0, e_wb_alu(), "imm_wb");
    end

    instr = I_SW;
    step(0, 0, e_fetch(0), "sw_fetch_wait0");
    step(0, 0, e_fetch(0), "sw_fetch_wait1");
    step(1, 0, e_fetch(1), "sw_fetch");
    step(1, 0, e_decode(), "sw_decode");
    step(1, 0, e_mem_addr(), "sw_addr");
    step(0, 0, e_mem_wr(), "sw_wr_wait");
    step(1, 0, e_mem_wr(), "sw_wr_done");

    instr = I_LW;
    step(1, 0, e_fetch(1), "lw_fetch");
    step(1, 0, e_decode(), "lw_decode");
    step(1, 0, e_mem_addr(), "lw_addr");
    for (int i = 0; i < 3; i++) step(0, 0, e_mem_rd(), "lw_rd_wait");
    step(1, 0, e_mem_rd(), "lw_rd_done");
    step(1, 0, e_wb_mem(), "lw_wb");

    instr = I_BEQ;
    step(1, 0, e_fetch(1), "beq_t_fetch");
    step(1, 0, e_decode(), "beq_t_decode");
    step(1, 1, e_branch(1), "beq_taken");
    step(1, 0, e_fetch(1), "beq_nt_fetch");
    step(1, 1, e_decode(), "beq_nt_decode_zero_ignored");
    step(1, 0, e_branch(0), "beq_not_taken");
    instr = I_ADD;
    step(1, 0, e_fetch(1), "fetch_after_branch");
    step(1, 0, e_decode(), "add2_decode");
    step(1, 0, e_exec_r(ADD), "add2_exec");
    step(1, 0, e_wb_alu(), "add2_wb");

    instr = I_SUB;
    step(1, 0, e_fetch(1), "sub_fetch");
    step(1, 0, e_decode(), "sub_decode");
    for (int i = 0; i < 20; i++) step(i[0], 1, e_trap(), "sub_trap");
    async_reset("rst_clears_illegal");
    release_reset();

    instr = I_JAL;
    step(1, 0, e_fetch(1), "jal_fetch");
    step(1, 0, e_decode(), "jal_decode");
    for (int i = 0; i < 20; i++) step(1, i[1], e_trap(), "jal_trap");
    async_reset("rst_from_trap");
    release_reset();

    step(0, 0, e_fetch(0), "fetch_wait_a");
    step(0, 0, e_fetch(0), "fetch_wait_b");
    async_reset("rst_in_fetch_wait");
    release_reset();
    instr = I_ADD;
    step(1, 0, e_fetch(1), "fetch_after_rst");

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
